// File: rtl/constants_pkg.sv
// Shared types and constants for the register-file access controller.
//   REGISTER_DATA_BITS : default width of register data, operands and result
//   reg_addr_t         : 4-bit register-file address
//   rfc_state_t        : controller FSM state encoding
package constants_pkg;

    localparam int REGISTER_DATA_BITS = 16;

    typedef logic [3:0] reg_addr_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        READ     = 3'd1,
        ISSUE    = 3'd2,
        WAIT_RES = 3'd3,
        WRITE    = 3'd4
    } rfc_state_t;

endpackage

// File: rtl/regfile_access_ctrl.sv
// Master side of the register-file port interface. Takes one decoded op at a
// time, reads its sources through rd0/rd1, hands the operands to the ALU and
// writes the ALU result back through the write port.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | req_ready high, waiting for a decoded op
// READ     | one cycle, read ports enabled, operands captured at the edge
// ISSUE    | op_valid high, operands held until the ALU takes them
// WAIT_RES | res_ready high, waiting for the ALU result
// WRITE    | one cycle, wr_enable high with latched destination and result
//
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   req_*                          decoded op handshake and fields
//   rd0_*, rd1_*                   register-file read ports (combinational data)
//   wr_*                           register-file write port
//   op_valid/op_ready, op_a/op_b   operand handshake to the ALU
//   res_valid/res_ready, res_data  result handshake from the ALU
//   busy                           controller not idle
module regfile_access_ctrl
    import constants_pkg::*;
#(
    parameter int DATA_BITS = REGISTER_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  reg_addr_t            req_src0,
    input  reg_addr_t            req_src1,
    input  logic                 req_use0,
    input  logic                 req_use1,
    input  reg_addr_t            req_dst,
    input  logic                 req_wr,
    output reg_addr_t            rd0_addr,
    output logic                 rd0_enable,
    input  logic [DATA_BITS-1:0] rd0_data,
    output reg_addr_t            rd1_addr,
    output logic                 rd1_enable,
    input  logic [DATA_BITS-1:0] rd1_data,
    output reg_addr_t            wr_addr,
    output logic                 wr_enable,
    output logic [DATA_BITS-1:0] wr_data,
    output logic                 op_valid,
    input  logic                 op_ready,
    output logic [DATA_BITS-1:0] op_a,
    output logic [DATA_BITS-1:0] op_b,
    input  logic                 res_valid,
    output logic                 res_ready,
    input  logic [DATA_BITS-1:0] res_data,
    output logic                 busy
);

    rfc_state_t           state_q, state_d;
    reg_addr_t            src0_q, src0_d;
    reg_addr_t            src1_q, src1_d;
    reg_addr_t            dst_q, dst_d;
    logic                 use0_q, use0_d;
    logic                 use1_q, use1_d;
    logic                 wr_q, wr_d;
    logic [DATA_BITS-1:0] op_a_q, op_a_d;
    logic [DATA_BITS-1:0] op_b_q, op_b_d;
    reg_addr_t            wr_addr_q, wr_addr_d;
    logic [DATA_BITS-1:0] wr_data_q, wr_data_d;

    always_comb begin
        state_d   = state_q;
        src0_d    = src0_q;
        src1_d    = src1_q;
        dst_d     = dst_q;
        use0_d    = use0_q;
        use1_d    = use1_q;
        wr_d      = wr_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    src0_d  = req_src0;
                    src1_d  = req_src1;
                    use0_d  = req_use0;
                    use1_d  = req_use1;
                    dst_d   = req_dst;
                    wr_d    = req_wr;
                    state_d = READ;
                end
            end
            READ: begin
                // Unused sources read as zero rather than whatever the port returns.
                op_a_d  = use0_q ? rd0_data : '0;
                op_b_d  = use1_q ? rd1_data : '0;
                state_d = ISSUE;
            end
            ISSUE: begin
                if (op_ready) begin
                    state_d = wr_q ? WAIT_RES : IDLE;
                end
            end
            WAIT_RES: begin
                if (res_valid) begin
                    wr_data_d = res_data;
                    wr_addr_d = dst_q;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            src0_q    <= '0;
            src1_q    <= '0;
            dst_q     <= '0;
            use0_q    <= 1'b0;
            use1_q    <= 1'b0;
            wr_q      <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            src0_q    <= src0_d;
            src1_q    <= src1_d;
            dst_q     <= dst_d;
            use0_q    <= use0_d;
            use1_q    <= use1_d;
            wr_q      <= wr_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Read addresses follow the latched sources, so they hold their last
    // value outside READ; only the enables are qualified by state.
    assign rd0_addr   = src0_q;
    assign rd1_addr   = src1_q;
    assign rd0_enable = (state_q == READ) && use0_q;
    assign rd1_enable = (state_q == READ) && use1_q;

    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_enable  = (state_q == WRITE);

    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign op_valid   = (state_q == ISSUE);
    assign res_ready  = (state_q == WAIT_RES);

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench: controller + behavioural register file + adder ALU with
// configurable operand stall and result delay.
module tb_regfile_access_ctrl;
    import constants_pkg::*;

    localparam int D = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    reg_addr_t    req_src0, req_src1, req_dst;
    logic         req_use0, req_use1, req_wr;
    reg_addr_t    rd0_addr, rd1_addr, wr_addr;
    logic         rd0_enable, rd1_enable, wr_enable;
    logic [D-1:0] rd0_data, rd1_data, wr_data;
    logic         op_valid, op_ready, res_valid, res_ready, busy;
    logic [D-1:0] op_a, op_b, res_data;

    always #5 clk = ~clk;

    regfile_access_ctrl #(.DATA_BITS(D)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src0(req_src0), .req_src1(req_src1),
        .req_use0(req_use0), .req_use1(req_use1),
        .req_dst(req_dst), .req_wr(req_wr),
        .rd0_addr(rd0_addr), .rd0_enable(rd0_enable), .rd0_data(rd0_data),
        .rd1_addr(rd1_addr), .rd1_enable(rd1_enable), .rd1_data(rd1_data),
        .wr_addr(wr_addr), .wr_enable(wr_enable), .wr_data(wr_data),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy)
    );

    // register file with a bench-side preload port
    logic [D-1:0] rf [16];
    logic         pl_en = 1'b0;
    reg_addr_t    pl_addr;
    logic [D-1:0] pl_data;

    always_ff @(posedge clk) begin
        if (wr_enable)  rf[wr_addr] <= wr_data;
        else if (pl_en) rf[pl_addr] <= pl_data;
    end
    assign rd0_data = rf[rd0_addr];
    assign rd1_data = rf[rd1_addr];

    // adder ALU model
    int           cfg_op_stall = 0;
    int           cfg_res_delay = 0;
    int           op_wait, res_wait;
    logic         alu_pend;
    logic [D-1:0] alu_res;

    assign op_ready  = op_valid && (op_wait >= cfg_op_stall);
    assign res_valid = alu_pend && (res_wait >= cfg_res_delay);
    assign res_data  = alu_res;

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_pend <= 1'b0;
            op_wait  <= 0;
            res_wait <= 0;
            alu_res  <= '0;
        end else begin
            if (res_valid && res_ready) alu_pend <= 1'b0;
            else if (alu_pend)          res_wait <= res_wait + 1;
            if (op_valid && !op_ready)  op_wait <= op_wait + 1;
            if (op_valid && op_ready) begin
                alu_pend <= 1'b1;
                alu_res  <= op_a + op_b;
                op_wait  <= 0;
                res_wait <= 0;
            end
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // per-op observations
    logic [D-1:0] got_a, got_b, wr_data_seen;
    reg_addr_t    wr_addr_seen, rd0_addr_seen, rd1_addr_seen;
    logic         op_seen, a_stable, rd1_seen, rd0_en_c1;
    int           wr_cnt, wr_cyc, ready_cyc;

    task automatic preload(input reg_addr_t a, input logic [D-1:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk);
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // called at a negedge; returns at the negedge where req_ready is back
    task automatic run_op(input reg_addr_t s0, input reg_addr_t s1, input logic u0,
                          input logic u1, input reg_addr_t d, input logic w,
                          input int ost, input int rdl);
        cfg_op_stall = ost; cfg_res_delay = rdl;
        req_src0 = s0; req_src1 = s1; req_use0 = u0; req_use1 = u1;
        req_dst = d; req_wr = w; req_valid = 1'b1;
        chk("accept_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        op_seen = 0; a_stable = 1; rd1_seen = 0; wr_cnt = 0; wr_cyc = 0; ready_cyc = 0;
        got_a = '0; got_b = '0; rd0_en_c1 = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (c == 1) begin
                rd0_en_c1 = rd0_enable; rd0_addr_seen = rd0_addr; rd1_addr_seen = rd1_addr;
            end
            if (op_valid) begin
                if (!op_seen) begin
                    op_seen = 1; got_a = op_a; got_b = op_b;
                end else if (op_a !== got_a || op_b !== got_b) begin
                    a_stable = 0;
                end
            end
            if (rd1_enable) rd1_seen = 1;
            if (wr_enable) begin
                wr_cnt++; wr_cyc = c; wr_addr_seen = wr_addr; wr_data_seen = wr_data;
            end
            if (req_ready) begin
                ready_cyc = c;
                break;
            end
        end
        if (ready_cyc == 0) chk("op_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic seen_rr;
        logic seen_wr;
        logic seen_busy;
        reset = 1'b1; req_valid = 1'b0;
        req_src0 = '0; req_src1 = '0; req_dst = '0;
        req_use0 = 0; req_use1 = 0; req_wr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_enables", {28'd0, rd0_enable, rd1_enable, wr_enable, op_valid}, 32'd0);
        chk("rst_res_ready", {31'd0, res_ready}, 32'd0);
        chk("rst_data", {op_a, wr_data}, 32'd0);
        reset = 1'b0;

        // 1: basic op, no stalls
        preload(4'd1, 16'd5);
        preload(4'd2, 16'd7);
        preload(4'd3, 16'd0);
        run_op(4'd1, 4'd2, 1, 1, 4'd3, 1, 0, 0);
        chk("t1_rd0", {27'd0, rd0_en_c1, rd0_addr_seen}, {27'd0, 1'b1, 4'd1});
        chk("t1_rd1_addr", {28'd0, rd1_addr_seen}, 32'd2);
        chk("t1_op_a", {16'd0, got_a}, 32'd5);
        chk("t1_op_b", {16'd0, got_b}, 32'd7);
        chk("t1_wr_cnt", wr_cnt, 32'd1);
        chk("t1_wr_cyc", wr_cyc, 32'd4);
        chk("t1_wr_addr", {28'd0, wr_addr_seen}, 32'd3);
        chk("t1_wr_data", {16'd0, wr_data_seen}, 32'd12);
        chk("t1_r3", {16'd0, rf[3]}, 32'd12);
        chk("t1_ready_cyc", ready_cyc, 32'd5);

        // 2: operand stall 3, result delay 2
        preload(4'd3, 16'd0);
        run_op(4'd1, 4'd2, 1, 1, 4'd3, 1, 3, 2);
        chk("t2_stable", {31'd0, a_stable}, 32'd1);
        chk("t2_op_ab", {got_a, got_b}, {16'd5, 16'd7});
        chk("t2_wr_cnt", wr_cnt, 32'd1);
        chk("t2_wr_cyc", wr_cyc, 32'd9);
        chk("t2_r3", {16'd0, rf[3]}, 32'd12);

        // 3: single operand, no write-back
        preload(4'd5, 16'd77);
        run_op(4'd1, 4'd2, 1, 0, 4'd5, 0, 0, 0);
        chk("t3_op_a", {16'd0, got_a}, 32'd5);
        chk("t3_op_b", {16'd0, got_b}, 32'd0);
        chk("t3_rd1_en", {31'd0, rd1_seen}, 32'd0);
        chk("t3_wr_cnt", wr_cnt, 32'd0);
        chk("t3_ready_cyc", ready_cyc, 32'd3);
        chk("t3_r5", {16'd0, rf[5]}, 32'd77);

        // 4: back-to-back with read-after-write on R3
        preload(4'd3, 16'd0);
        run_op(4'd1, 4'd2, 1, 1, 4'd3, 1, 0, 0);
        chk("t4a_ready_cyc", ready_cyc, 32'd5);
        run_op(4'd3, 4'd3, 1, 1, 4'd4, 1, 0, 0);
        chk("t4b_op_ab", {got_a, got_b}, {16'd12, 16'd12});
        chk("t4b_wr_cyc", wr_cyc, 32'd4);
        chk("t4b_r4", {16'd0, rf[4]}, 32'd24);

        // 5: reset during WAIT_RES, with req_valid held during reset
        preload(4'd3, 16'd99);
        cfg_op_stall = 0; cfg_res_delay = 20;
        req_src0 = 4'd1; req_src1 = 4'd2; req_use0 = 1; req_use1 = 1;
        req_dst = 4'd3; req_wr = 1; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        seen_rr = 0;
        for (int c = 0; c < 10; c++) begin
            if (res_ready) begin
                seen_rr = 1;
                break;
            end
            @(negedge clk);
        end
        chk("t5_in_wait_res", {31'd0, seen_rr}, 32'd1);
        reset = 1'b1; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; req_valid = 1'b0;
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_req_ready", {31'd0, req_ready}, 32'd1);
        chk("t5_enables", {27'd0, rd0_enable, rd1_enable, wr_enable, op_valid, res_ready}, 32'd0);
        chk("t5_data", {op_a, op_b}, 32'd0);
        chk("t5_wr", {12'd0, wr_data, wr_addr}, 32'd0);
        chk("t5_rd_addr", {24'd0, rd0_addr, rd1_addr}, 32'd0);
        seen_wr = 0; seen_busy = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (wr_enable) seen_wr = 1;
            if (busy) seen_busy = 1;
        end
        chk("t5_no_write", {31'd0, seen_wr}, 32'd0);
        chk("t5_not_accepted", {31'd0, seen_busy}, 32'd0);
        chk("t5_r3", {16'd0, rf[3]}, 32'd99);

        // 6: wrap-around
        preload(4'd1, 16'hFFFF);
        preload(4'd2, 16'd1);
        preload(4'd3, 16'd55);
        run_op(4'd1, 4'd2, 1, 1, 4'd3, 1, 0, 0);
        chk("t6_op_a", {16'd0, got_a}, 32'h0000FFFF);
        chk("t6_wr_data", {16'd0, wr_data_seen}, 32'd0);
        chk("t6_r3", {16'd0, rf[3]}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
